hit_judge: RTL and testbench

Upstream judge stage for the score display. It tracks the single active mole and times how long it has been up in game ticks. It matches debounced key presses against the mole's hole and emits a one-cycle `hit_success` pulse plus a 3-bit `round_score` that the score stage accumulates. It also enforces a cooldown so that no score award arrives while the score stage is still draining the previous one.

---
 rtl/hit_judge.sv | 187 ++++++++++++++++++
 tb/tb_hit_judge.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hit_judge.sv
// hit_judge: judge stage ahead of the score display.
//
// Tracks the single active mole, ages it in game ticks, matches key presses
// against the mole's hole and emits a one-cycle hit_success pulse with a
// 3-bit round_score, or a one-cycle miss pulse on timeout. A cooldown of GAP
// cycles follows every hit or miss so the score stage can drain the previous
// award before the next one arrives.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   tick              game time-base strobe (one cycle)
//   spawn, spawn_pos  new-mole request and its hole index
//   key_valid,key_pos debounced key press and its hole index
//   mole_visible      a mole is up
//   mole_pos          hole of the current or last mole
//   hit_success       one-cycle pulse on a correct hit
//   round_score       score of the last hit, held until the next hit
//   miss              one-cycle pulse on timeout
//
// Optional feature: define HIT_JUDGE_COMBO_EN to add a 2-bit combo counter
// that boosts the score of consecutive hits (saturating at +2, capped at 7).
module hit_judge #(
  parameter logic [3:0] NUM_HOLES  = 4'd9,
  parameter logic [7:0] TICK_LIMIT = 8'd60,
  parameter logic [7:0] BIN_TICKS  = 8'd12,
  parameter logic [3:0] GAP        = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       spawn,
  input  logic [3:0] spawn_pos,
  input  logic       key_valid,
  input  logic [3:0] key_pos,
  output logic       mole_visible,
  output logic [3:0] mole_pos,
  output logic       hit_success,
  output logic [2:0] round_score,
  output logic       miss
);

  typedef enum logic [1:0] {StIdle, StUp, StCool} state_e;

  state_e     state_q, state_d;
  logic [7:0] age_q, age_d;
  logic [7:0] bin_cnt_q, bin_cnt_d;
  logic [2:0] bin_idx_q, bin_idx_d;
  logic [3:0] cool_q, cool_d;
  logic [3:0] mole_pos_q, mole_pos_d;
  logic       mole_visible_q, mole_visible_d;
  logic       hit_success_q, hit_success_d;
  logic [2:0] round_score_q, round_score_d;
  logic       miss_q, miss_d;

  logic       is_hit;
  logic [7:0] age_inc;
  logic [2:0] base_score;
  logic [2:0] hit_score;

  assign is_hit     = key_valid && (key_pos == mole_pos_q);
  assign age_inc    = (age_q >= TICK_LIMIT) ? TICK_LIMIT : age_q + 8'd1;
  // bin_idx saturates at 4, so the base score never drops below 1.
  assign base_score = 3'd5 - bin_idx_q;

`ifdef HIT_JUDGE_COMBO_EN
  logic [1:0] combo_q, combo_d;
  logic [3:0] score_sum;

  assign score_sum = {1'b0, base_score} + {2'b00, combo_q};
  assign hit_score = (score_sum > 4'd7) ? 3'd7 : score_sum[2:0];

  always_comb begin
    combo_d = combo_q;
    if (state_q == StUp) begin
      if (is_hit) begin
        combo_d = (combo_q == 2'd2) ? 2'd2 : combo_q + 2'd1;
      end else if (tick && (age_inc == TICK_LIMIT)) begin
        combo_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      combo_q <= 2'd0;
    end else begin
      combo_q <= combo_d;
    end
  end
`else
  assign hit_score = base_score;
`endif

  always_comb begin
    state_d        = state_q;
    age_d          = age_q;
    bin_cnt_d      = bin_cnt_q;
    bin_idx_d      = bin_idx_q;
    cool_d         = cool_q;
    mole_pos_d     = mole_pos_q;
    mole_visible_d = mole_visible_q;
    round_score_d  = round_score_q;
    hit_success_d  = 1'b0;
    miss_d         = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Out-of-range spawns are dropped; a simultaneous key is ignored.
        if (spawn && (spawn_pos < NUM_HOLES)) begin
          state_d        = StUp;
          mole_pos_d     = spawn_pos;
          mole_visible_d = 1'b1;
          age_d          = 8'd0;
          bin_cnt_d      = 8'd0;
          bin_idx_d      = 3'd0;
        end
      end
      StUp: begin
        // A hit takes priority over a coincident expiring tick.
        if (is_hit) begin
          state_d        = StCool;
          cool_d         = GAP - 4'd1;
          mole_visible_d = 1'b0;
          hit_success_d  = 1'b1;
          round_score_d  = hit_score;
        end else if (tick) begin
          age_d = age_inc;
          if (bin_cnt_q == BIN_TICKS - 8'd1) begin
            bin_cnt_d = 8'd0;
            bin_idx_d = (bin_idx_q == 3'd4) ? 3'd4 : bin_idx_q + 3'd1;
          end else begin
            bin_cnt_d = bin_cnt_q + 8'd1;
          end
          if (age_inc == TICK_LIMIT) begin
            state_d        = StCool;
            cool_d         = GAP - 4'd1;
            mole_visible_d = 1'b0;
            miss_d         = 1'b1;
          end
        end
      end
      StCool: begin
        if (cool_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cool_d = cool_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      age_q          <= 8'd0;
      bin_cnt_q      <= 8'd0;
      bin_idx_q      <= 3'd0;
      cool_q         <= 4'd0;
      mole_pos_q     <= 4'd0;
      mole_visible_q <= 1'b0;
      hit_success_q  <= 1'b0;
      round_score_q  <= 3'd0;
      miss_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      age_q          <= age_d;
      bin_cnt_q      <= bin_cnt_d;
      bin_idx_q      <= bin_idx_d;
      cool_q         <= cool_d;
      mole_pos_q     <= mole_pos_d;
      mole_visible_q <= mole_visible_d;
      hit_success_q  <= hit_success_d;
      round_score_q  <= round_score_d;
      miss_q         <= miss_d;
    end
  end

  assign mole_visible = mole_visible_q;
  assign mole_pos     = mole_pos_q;
  assign hit_success  = hit_success_q;
  assign round_score  = round_score_q;
  assign miss         = miss_q;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge with default parameters. Expected scores
// depend on whether HIT_JUDGE_COMBO_EN is defined.
module tb_hit_judge;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       spawn = 1'b0;
  logic [3:0] spawn_pos = 4'd0;
  logic       key_valid = 1'b0;
  logic [3:0] key_pos = 4'd0;
  logic       mole_visible;
  logic [3:0] mole_pos;
  logic       hit_success;
  logic [2:0] round_score;
  logic       miss;

  int checks = 0;
  int errors = 0;

`ifdef HIT_JUDGE_COMBO_EN
  localparam logic [7:0] ExpB  = 8'd6;
  localparam logic [7:0] ExpT2 = 8'd5;
  localparam logic [7:0] ExpT5 = 8'd3;
  localparam logic [7:0] ExpH2 = 8'd6;
  localparam logic [7:0] ExpH3 = 8'd7;
  localparam logic [7:0] ExpH4 = 8'd7;
`else
  localparam logic [7:0] ExpB  = 8'd5;
  localparam logic [7:0] ExpT2 = 8'd3;
  localparam logic [7:0] ExpT5 = 8'd1;
  localparam logic [7:0] ExpH2 = 8'd5;
  localparam logic [7:0] ExpH3 = 8'd5;
  localparam logic [7:0] ExpH4 = 8'd5;
`endif

  hit_judge dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .spawn        (spawn),
    .spawn_pos    (spawn_pos),
    .key_valid    (key_valid),
    .key_pos      (key_pos),
    .mole_visible (mole_visible),
    .mole_pos     (mole_pos),
    .hit_success  (hit_success),
    .round_score  (round_score),
    .miss         (miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance past one active edge; outputs are then stable for sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_spawn(input logic [3:0] pos);
    spawn     = 1'b1;
    spawn_pos = pos;
    cyc();
    spawn     = 1'b0;
  endtask

  task automatic do_key(input logic [3:0] pos);
    key_valid = 1'b1;
    key_pos   = pos;
    cyc();
    key_valid = 1'b0;
  endtask

  // Spawn, hit immediately, check the score, then wait out the cooldown.
  task automatic quick_hit(input string tag, input logic [3:0] pos, input logic [7:0] exp);
    do_spawn(pos);
    chk({tag, "_vis"}, {7'd0, mole_visible}, 8'd1);
    do_key(pos);
    chk({tag, "_hit"}, {7'd0, hit_success}, 8'd1);
    chk({tag, "_score"}, {5'd0, round_score}, exp);
    repeat (8) cyc();
  endtask

  // Spawn and let the mole time out, then wait out the cooldown.
  task automatic full_miss(input string tag, input logic [3:0] pos);
    do_spawn(pos);
    tick = 1'b1;
    repeat (60) cyc();
    tick = 1'b0;
    chk({tag, "_miss"}, {7'd0, miss}, 8'd1);
    chk({tag, "_nohit"}, {7'd0, hit_success}, 8'd0);
    repeat (8) cyc();
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_vis", {7'd0, mole_visible}, 8'd0);
    chk("rst_pos", {4'd0, mole_pos}, 8'd0);
    chk("rst_hit", {7'd0, hit_success}, 8'd0);
    chk("rst_score", {5'd0, round_score}, 8'd0);
    chk("rst_miss", {7'd0, miss}, 8'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // Immediate hit on hole 3.
    do_spawn(4'd3);
    chk("a_vis", {7'd0, mole_visible}, 8'd1);
    chk("a_pos", {4'd0, mole_pos}, 8'd3);
    do_key(4'd3);
    chk("a_hit", {7'd0, hit_success}, 8'd1);
    chk("a_score", {5'd0, round_score}, 8'd5);
    chk("a_vis0", {7'd0, mole_visible}, 8'd0);
    cyc();
    chk("a_pulse", {7'd0, hit_success}, 8'd0);
    chk("a_hold", {5'd0, round_score}, 8'd5);
    repeat (6) cyc();
    // Last cooldown cycle: spawn must be dropped.
    do_spawn(4'd1);
    chk("exit_vis", {7'd0, mole_visible}, 8'd0);
    chk("exit_pos", {4'd0, mole_pos}, 8'd3);
    do_spawn(4'd1);
    chk("b_vis", {7'd0, mole_visible}, 8'd1);
    chk("b_pos", {4'd0, mole_pos}, 8'd1);
    // Spawn during UP ignored; wrong hole ignored.
    do_spawn(4'd5);
    chk("upspawn_pos", {4'd0, mole_pos}, 8'd1);
    do_key(4'd0);
    chk("wrong_hit", {7'd0, hit_success}, 8'd0);
    chk("wrong_vis", {7'd0, mole_visible}, 8'd1);
    do_key(4'd1);
    chk("b_hit", {7'd0, hit_success}, 8'd1);
    chk("b_score", {5'd0, round_score}, ExpB);
    repeat (8) cyc();

    // 30 ticks then hit: bin_idx 2.
    do_spawn(4'd2);
    tick = 1'b1;
    repeat (30) cyc();
    tick = 1'b0;
    do_key(4'd2);
    chk("t2_hit", {7'd0, hit_success}, 8'd1);
    chk("t2_score", {5'd0, round_score}, ExpT2);
    repeat (8) cyc();

    // 59 ticks, then expiring tick coincident with correct key: hit wins.
    do_spawn(4'd7);
    tick = 1'b1;
    repeat (59) cyc();
    chk("t5_vis", {7'd0, mole_visible}, 8'd1);
    key_valid = 1'b1;
    key_pos   = 4'd7;
    cyc();
    key_valid = 1'b0;
    tick      = 1'b0;
    chk("t5_hit", {7'd0, hit_success}, 8'd1);
    chk("t5_score", {5'd0, round_score}, ExpT5);
    chk("t5_miss", {7'd0, miss}, 8'd0);
    cyc();
    chk("t5_miss2", {7'd0, miss}, 8'd0);
    repeat (8) cyc();

    // Timeout on hole 4.
    do_spawn(4'd4);
    tick = 1'b1;
    repeat (59) cyc();
    chk("t3_pre_miss", {7'd0, miss}, 8'd0);
    chk("t3_pre_vis", {7'd0, mole_visible}, 8'd1);
    cyc();
    tick = 1'b0;
    chk("t3_miss", {7'd0, miss}, 8'd1);
    chk("t3_vis", {7'd0, mole_visible}, 8'd0);
    chk("t3_nohit", {7'd0, hit_success}, 8'd0);
    cyc();
    chk("t3_pulse", {7'd0, miss}, 8'd0);
    do_key(4'd4);
    chk("t3_latekey", {7'd0, hit_success}, 8'd0);
    repeat (8) cyc();

    // Out-of-range spawn in IDLE.
    do_spawn(4'd9);
    chk("oob_vis", {7'd0, mole_visible}, 8'd0);
    chk("oob_pos", {4'd0, mole_pos}, 8'd4);

    // Consecutive immediate hits after a miss.
    quick_hit("h1", 4'd0, 8'd5);
    quick_hit("h2", 4'd8, ExpH2);
    quick_hit("h3", 4'd5, ExpH3);
    quick_hit("h4", 4'd6, ExpH4);
    full_miss("m2", 4'd2);
    quick_hit("h5", 4'd3, 8'd5);

    // Reset asserted mid-UP clears outputs without waiting for a clock.
    do_spawn(4'd6);
    chk("r_vis", {7'd0, mole_visible}, 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("r_vis0", {7'd0, mole_visible}, 8'd0);
    chk("r_pos0", {4'd0, mole_pos}, 8'd0);
    chk("r_score0", {5'd0, round_score}, 8'd0);
    chk("r_hit0", {7'd0, hit_success}, 8'd0);
    chk("r_miss0", {7'd0, miss}, 8'd0);
    #1 rst = 1'b0;
    cyc();
    do_key(4'd6);
    chk("r_idle_key", {7'd0, hit_success}, 8'd0);
    chk("r_idle_vis", {7'd0, mole_visible}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
